// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
//   Shared types for the N-channel stream multiplexer.
//   mode_t selects how an idle (unlocked) mux picks its next channel:
//     MODE_SEL   - external channel index
//     MODE_FIXED - lowest-index valid channel wins
//     MODE_RR    - round-robin starting at the rotating pointer
//   Encoding 3 is reserved and grants nothing while unlocked.
// ---------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic [1:0] {
        MODE_SEL   = 2'd0,
        MODE_FIXED = 2'd1,
        MODE_RR    = 2'd2
    } mode_t;

endpackage

// File: rtl/stream_muxn_if.sv
// ---------------------------------------------------------------------------
// stream_muxn_if
//   Handshake bundle between NUM_CH producers, the mux and one consumer.
//   Signals:
//     in_data   NUM_CH*WIDTH  packed input beats, channel i at [i*WIDTH +: WIDTH]
//     in_valid  NUM_CH        per-channel beat valid
//     in_last   NUM_CH        per-channel end-of-packet marker
//     in_ready  NUM_CH        per-channel accept (at most one bit high)
//     out_data  WIDTH         registered output beat
//     out_valid 1             output beat valid
//     out_last  1             end-of-packet marker of the output beat
//     out_chan  CH_W          source channel of the output beat
//     out_ready 1             downstream accept
//   Modports:
//     slave  - the mux itself
//     master - the surrounding producers/consumer (or a testbench)
// ---------------------------------------------------------------------------
interface stream_muxn_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_last;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_last;
    logic [CH_W-1:0]         out_chan;
    logic                    out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_chan
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_chan
    );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational channel picker for stream_muxn.
//   Ports:
//     req      in   N   per-channel request (in_valid)
//     ptr      in   W   round-robin start index
//     mode     in   2   arbitration mode (mode_t)
//     sel      in   W   channel index for MODE_SEL
//     lock     in   1   a packet is in progress
//     lock_ch  in   W   channel owning the open packet
//     grant    out  N   one-hot grant, or zero
//     winner   out  W   index of the granted channel (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  mode_t        mode,
    input  logic [W-1:0] sel,
    input  logic         lock,
    input  logic [W-1:0] lock_ch,
    output logic [N-1:0] grant,
    output logic [W-1:0] winner
);

    logic found;

    // Pick a winner. An open packet overrides mode and sel so that beats of
    // one packet are never interleaved with another channel. Index matching is
    // done by comparison loops so that a sel value beyond NUM_CH simply finds
    // nothing instead of indexing out of range.
    always_comb begin
        int c;
        found  = 1'b0;
        winner = '0;
        c      = 0;
        if (lock) begin
            for (int i = 0; i < N; i++) begin
                if (lock_ch == W'(i) && req[i]) begin
                    found  = 1'b1;
                    winner = W'(i);
                end
            end
        end else begin
            case (mode)
                MODE_SEL: begin
                    for (int i = 0; i < N; i++) begin
                        if (sel == W'(i) && req[i]) begin
                            found  = 1'b1;
                            winner = W'(i);
                        end
                    end
                end
                MODE_FIXED: begin
                    for (int i = 0; i < N; i++) begin
                        if (!found && req[i]) begin
                            found  = 1'b1;
                            winner = W'(i);
                        end
                    end
                end
                MODE_RR: begin
                    // Visit ptr, ptr+1, ... wrapping back to 0.
                    for (int j = 0; j < N; j++) begin
                        c = j + int'(ptr);
                        if (c >= N) begin
                            c = c - N;
                        end
                        for (int i = 0; i < N; i++) begin
                            if (!found && i == c && req[i]) begin
                                found  = 1'b1;
                                winner = W'(i);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Expand the winner index into a one-hot grant.
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = found && (winner == W'(i));
        end
    end

endmodule

// File: rtl/stream_muxn.sv
// ---------------------------------------------------------------------------
// stream_muxn
//   N-channel, WIDTH-bit stream multiplexer with a one-beat registered output.
//   Keeps packets whole: once a channel's first non-last beat is taken, only
//   that channel is served until its last beat passes.
//   Ports:
//     clk      in   1      rising-edge clock
//     reset_n  in   1      asynchronous active-low reset
//     mode     in   2      arbitration mode (mode_t)
//     sel      in   CH_W   channel index used in MODE_SEL
//     bus      slave       stream handshake bundle (see stream_muxn_if)
// ---------------------------------------------------------------------------
module stream_muxn
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  mode_t           mode,
    input  logic [CH_W-1:0] sel,
    stream_muxn_if.slave    bus
);

    logic [WIDTH-1:0]  outData_q,  outData_d;
    logic              outValid_q, outValid_d;
    logic              outLast_q,  outLast_d;
    logic [CH_W-1:0]   outChan_q,  outChan_d;
    logic              lock_q,     lock_d;
    logic [CH_W-1:0]   lockCh_q,   lockCh_d;
    logic [CH_W-1:0]   rrPtr_q,    rrPtr_d;

    logic              loadEn;
    logic              accept;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   winner;
    logic [WIDTH-1:0]  selData;
    logic              selLast;

    rr_arbiter #(
        .N (NUM_CH),
        .W (CH_W)
    ) u_arb (
        .req     (bus.in_valid),
        .ptr     (rrPtr_q),
        .mode    (mode),
        .sel     (sel),
        .lock    (lock_q),
        .lock_ch (lockCh_q),
        .grant   (grant),
        .winner  (winner)
    );

    // The output slot can take a new beat when empty or draining this cycle,
    // which gives full throughput under continuous out_ready.
    assign loadEn       = !outValid_q || bus.out_ready;
    assign accept       = loadEn && (|grant);
    assign bus.in_ready = loadEn ? grant : '0;

    // AND-OR select of the granted channel; grant is one-hot or zero.
    always_comb begin
        selData = '0;
        selLast = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            selData = selData | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
            selLast = selLast | (bus.in_last[i] & grant[i]);
        end
    end

    // Next-state for the output slot, packet lock and round-robin pointer.
    // When the slot loads but nothing is granted it goes empty while the old
    // data/last/chan are left in place.
    always_comb begin
        outData_d  = outData_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        outChan_d  = outChan_q;
        lock_d     = lock_q;
        lockCh_d   = lockCh_q;
        rrPtr_d    = rrPtr_q;
        if (loadEn) begin
            outValid_d = accept;
        end
        if (accept) begin
            outData_d = selData;
            outLast_d = selLast;
            outChan_d = winner;
            if (selLast) begin
                lock_d = 1'b0;
                if (mode == MODE_RR) begin
                    rrPtr_d = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + CH_W'(1);
                end
            end else begin
                lock_d   = 1'b1;
                lockCh_d = winner;
            end
        end
    end

    // State registers; reset empties the slot and abandons any open packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outData_q  <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            outChan_q  <= '0;
            lock_q     <= 1'b0;
            lockCh_q   <= '0;
            rrPtr_q    <= '0;
        end else begin
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
            outChan_q  <= outChan_d;
            lock_q     <= lock_d;
            lockCh_q   <= lockCh_d;
            rrPtr_q    <= rrPtr_d;
        end
    end

    assign bus.out_data  = outData_q;
    assign bus.out_valid = outValid_q;
    assign bus.out_last  = outLast_q;
    assign bus.out_chan  = outChan_q;

endmodule

// File: tb/tb_stream_muxn.sv
// ---------------------------------------------------------------------------
// tb_stream_muxn
//   Directed bench for stream_muxn with NUM_CH=4, WIDTH=8. Each step drives
//   the inputs just after a rising edge, checks in_ready once it settles,
//   then checks the registered outputs one time unit after the next edge.
// ---------------------------------------------------------------------------
module tb_stream_muxn;
    import mux_pkg::*;

    logic       clk;
    logic       reset_n;
    mode_t      mode;
    logic [1:0] sel;
    int         checkCount;
    int         passCount;

    stream_muxn_if #(.WIDTH(8), .NUM_CH(4)) bus ();

    stream_muxn #(.WIDTH(8), .NUM_CH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mode    (mode),
        .sel     (sel),
        .bus     (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one set of inputs and let combinational in_ready settle.
    task automatic applyStimulus(input mode_t m, input logic [1:0] s,
                                 input logic [3:0] v, input logic [3:0] l,
                                 input logic [31:0] d, input logic r);
        mode          = m;
        sel           = s;
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.in_data   = d;
        bus.out_ready = r;
        #2;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the registered output beat.
    task automatic checkBeat(input string tag, input logic v, input logic [7:0] d,
                             input logic [1:0] c, input logic l);
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        checkOutput({tag, "_data"},  32'(bus.out_data),  32'(d));
        checkOutput({tag, "_chan"},  32'(bus.out_chan),  32'(c));
        checkOutput({tag, "_last"},  32'(bus.out_last),  32'(l));
    endtask

    initial begin
        logic [1:0] rrSeq [6];
        checkCount = 0;
        passCount  = 0;
        rrSeq      = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Reset state
        reset_n = 1'b0;
        applyStimulus(MODE_SEL, 2'd0, 4'b0000, 4'b0000, 32'h0, 1'b1);
        tick();
        tick();
        checkBeat("reset", 1'b0, 8'h00, 2'd0, 1'b0);
        reset_n = 1'b1;

        // 1: external select, single beat from ch2
        applyStimulus(MODE_SEL, 2'd2, 4'b0100, 4'b0100, 32'h00A5_0000, 1'b1);
        checkOutput("t1_in_ready", 32'(bus.in_ready), 32'h4);
        tick();
        checkBeat("t1_beat", 1'b1, 8'hA5, 2'd2, 1'b1);

        // Selected channel idle: slot empties, data holds
        applyStimulus(MODE_SEL, 2'd1, 4'b0100, 4'b0100, 32'h00A5_0000, 1'b1);
        checkOutput("t1_idle_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        checkOutput("t1_idle_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("t1_idle_data",  32'(bus.out_data),  32'hA5);

        // 2: fixed priority, ch1 starves ch3
        for (int k = 0; k < 3; k++) begin
            applyStimulus(MODE_FIXED, 2'd0, 4'b1010, 4'b1111, 32'h3300_1100, 1'b1);
            checkOutput("t2_in_ready", 32'(bus.in_ready), 32'h2);
            tick();
            checkBeat("t2_beat", 1'b1, 8'h11, 2'd1, 1'b1);
        end

        // 3: round-robin over all channels with wrap
        for (int k = 0; k < 6; k++) begin
            applyStimulus(MODE_RR, 2'd0, 4'b1111, 4'b1111, 32'h1312_1110, 1'b1);
            checkOutput("t3_in_ready", 32'(bus.in_ready), 32'(4'b0001 << rrSeq[k]));
            tick();
            checkBeat("t3_beat", 1'b1, 8'h10 + 8'(rrSeq[k]), rrSeq[k], 1'b1);
        end

        // 4: pointer is at 2; one ch0 beat moves it to 1
        applyStimulus(MODE_RR, 2'd0, 4'b0001, 4'b0001, 32'h0022_B110, 1'b1);
        checkOutput("t4_pre_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        checkBeat("t4_pre", 1'b1, 8'h10, 2'd0, 1'b0 | 1'b1);

        // ch1 three-beat packet; mode switched mid-packet must not break the lock
        applyStimulus(MODE_RR, 2'd0, 4'b0111, 4'b0101, 32'h0022_B110, 1'b1);
        checkOutput("t4_b1_in_ready", 32'(bus.in_ready), 32'h2);
        tick();
        checkBeat("t4_b1", 1'b1, 8'hB1, 2'd1, 1'b0);
        applyStimulus(MODE_FIXED, 2'd0, 4'b0111, 4'b0101, 32'h0022_B210, 1'b1);
        checkOutput("t4_b2_in_ready", 32'(bus.in_ready), 32'h2);
        tick();
        checkBeat("t4_b2", 1'b1, 8'hB2, 2'd1, 1'b0);
        applyStimulus(MODE_RR, 2'd0, 4'b0111, 4'b0111, 32'h0022_B310, 1'b1);
        tick();
        checkBeat("t4_b3", 1'b1, 8'hB3, 2'd1, 1'b1);
        applyStimulus(MODE_RR, 2'd0, 4'b0111, 4'b0101, 32'h0022_B410, 1'b1);
        checkOutput("t4_next_in_ready", 32'(bus.in_ready), 32'h4);
        tick();
        checkBeat("t4_next", 1'b1, 8'h22, 2'd2, 1'b1);

        // 5: backpressure for 5 cycles holds the ch2 beat
        for (int k = 0; k < 5; k++) begin
            applyStimulus(MODE_RR, 2'd0, 4'b1111, 4'b1111, 32'h4433_2211, 1'b0);
            checkOutput("t5_hold_in_ready", 32'(bus.in_ready), 32'h0);
            tick();
            checkBeat("t5_hold", 1'b1, 8'h22, 2'd2, 1'b1);
        end
        applyStimulus(MODE_RR, 2'd0, 4'b1111, 4'b1111, 32'h4433_2211, 1'b1);
        checkOutput("t5_rel_in_ready", 32'(bus.in_ready), 32'h8);
        tick();
        checkBeat("t5_rel", 1'b1, 8'h44, 2'd3, 1'b1);
        applyStimulus(MODE_RR, 2'd0, 4'b1111, 4'b1111, 32'h4433_2211, 1'b1);
        checkOutput("t5_next_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        checkBeat("t5_next", 1'b1, 8'h11, 2'd0, 1'b1);

        // 6: open a ch1 packet, hold it, then reset asynchronously
        applyStimulus(MODE_RR, 2'd0, 4'b0010, 4'b0000, 32'h0000_C100, 1'b1);
        checkOutput("t6_open_in_ready", 32'(bus.in_ready), 32'h2);
        tick();
        checkBeat("t6_open", 1'b1, 8'hC1, 2'd1, 1'b0);
        applyStimulus(MODE_RR, 2'd0, 4'b0010, 4'b0000, 32'h0000_C200, 1'b0);
        tick();
        checkBeat("t6_held", 1'b1, 8'hC1, 2'd1, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("t6_async_data",  32'(bus.out_data),  32'h0);
        tick();
        reset_n = 1'b1;
        applyStimulus(MODE_RR, 2'd0, 4'b1111, 4'b1111, 32'h4433_2211, 1'b1);
        checkOutput("t6_after_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        checkBeat("t6_after", 1'b1, 8'h11, 2'd0, 1'b1);

        // Reserved mode while unlocked grants nothing
        applyStimulus(mode_t'(2'd3), 2'd0, 4'b1111, 4'b1111, 32'h4433_2211, 1'b1);
        checkOutput("rsv_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        checkOutput("rsv_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("rsv_data",  32'(bus.out_data),  32'h11);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
